pmt_gate_sequencer: RTL and testbench
=====================================

// Module: pmt_gate_sequencer
// PURPOSE
// Acquisition sequencer for the photon counter. Clears the counter, then slices its free-running
// normal and lock-in counts into back-to-back gate windows of programmable length. Emits one
// result per window (count deltas plus bin index) over a valid/ready link to the host/FIFO side.
// Sits between the host register block and photon_counter; owns the counter's c_rst.
// PARAMETERS
// COUNTSIZE  32  width of counter inputs, gate period and result data
// BINSIZE    16  width of bin count / bin index
// PORTS
// c_clk          in   1          system clock; same clock as the counter
// c_rst          in   1          reset c_rst, asynchronous, active-high
// c_start        in   1          1-cycle pulse: begin acquisition (ignored unless IDLE)
// c_abort        in   1          1-cycle pulse: stop acquisition, discard partial bin
// c_gate_period  in   COUNTSIZE  window length in c_clk cycles; sampled at start
// c_num_bins     in   BINSIZE    windows to acquire; 0 = continuous; sampled at start
// c_ch1_cnt      in   COUNTSIZE  normal count from counter
// c_ch1_cnt_lck  in   COUNTSIZE  lock-in count from counter (two's-complement)
// c_cnt_clr      out  1          counter clear, drives counter c_rst
// c_busy         out  1          high in any state except IDLE
// c_bin_valid    out  1          result holding register full
// c_bin_ready    in   1          consumer accepts result when valid&&ready
// c_bin_cnt      out  COUNTSIZE  normal-count delta for the window
// c_bin_lck      out  COUNTSIZE  lock-in-count delta for the window (signed, mod 2^COUNTSIZE)
// c_bin_idx      out  BINSIZE    index of the window, 0-based
// c_overrun      out  1          sticky: a completed window was dropped
// BEHAVIOUR
// - Reset: state IDLE; c_cnt_clr=1 (counter held cleared); all other outputs 0; base regs 0.
// - States: IDLE -> CLEAR -> SETTLE -> RUN -> IDLE.
// - IDLE: c_cnt_clr=0. c_start && c_gate_period!=0 -> latch period/num_bins, clear c_overrun,
//   bin counter=0, go CLEAR. c_start with period 0 is ignored.
// - CLEAR: c_cnt_clr=1 for exactly one cycle; base_cnt=base_lck=0; go SETTLE.
// - SETTLE: one cycle; timer=1; go RUN.
// - RUN: timer increments each cycle; when timer==period (window = period cycles):
//   c_bin_cnt=c_ch1_cnt-base_cnt, c_bin_lck=c_ch1_cnt_lck-base_lck (modular, wrap-safe),
//   base<=current counts, timer<=1, idx<=bin counter, bin counter+1.
// - Windows are contiguous: every counter increment lands in exactly one bin; none lost/duplicated.
// - Completion: when bin counter reaches num_bins (num_bins!=0) after emitting -> IDLE.
//   Same-cycle as last emit; c_busy falls next cycle.
// - Output handshake: result register loads only if empty or consumed same cycle (valid&&ready).
//   Loading sets c_bin_valid next cycle. valid&&ready without new load clears c_bin_valid.
//   Data/idx stable while valid&&!ready.
// - Overrun: window completes while valid&&!ready -> new result dropped, c_overrun<=1 (sticky).
//   Bin counter still advances; idx gaps reveal the loss. Cleared only by accepted start or reset.
// - c_abort in CLEAR/SETTLE/RUN -> IDLE next cycle; partial window discarded.
//   Pending valid result kept until consumed. Abort same cycle as window completion:
//   the completed result is emitted, then IDLE.
// - c_start while busy ignored; c_abort in IDLE no effect.
// - Async c_rst mid-run: immediate return to reset values; pending result lost.
// - Timer and bin counters are COUNTSIZE/BINSIZE wide; period up to 2^COUNTSIZE-1 supported.
// TESTING
// - period=10, num_bins=3, ch1 edge every 2 clk, ready=1 -> 3 results idx 0,1,2, cnt=5 each.
//   c_busy low after idx 2.
// - Lock-in up=down=5 period, edges every clk, period=20 -> c_bin_lck ~0 each bin; sum of c_bin_cnt
//   equals total edges.
// - ready=0 for 3 windows, period=8 -> first result held stable; c_overrun=1; after ready=1,
//   next accepted idx=3.
// - Base counts preset near 2^32-1 (force counter inputs) -> delta correct across wrap, e.g. 0xFFFFFFFE->3 gives 5.
// - num_bins=0, abort at cycle 57 of period 20 -> 2 results (idx 0,1), partial bin dropped,
//   c_busy=0 at cycle 58; start w/ period 0 ignored.
// - c_rst asserted mid-RUN with valid pending -> all outputs 0, c_cnt_clr=1 immediately; clean restart.

Source files
------------

// File: rtl/pmt_gate_sequencer.sv
// pmt_gate_sequencer: acquisition sequencer for the photon counter.
// Clears the counter, then slices its free-running normal and lock-in counts
// into back-to-back gate windows and emits one result per window.
// Ports:
//   c_clk, c_rst            clock, async active-high reset
//   c_start, c_abort        acquisition control pulses
//   c_gate_period           window length in cycles (sampled at start)
//   c_num_bins              windows to acquire, 0 = continuous (sampled at start)
//   c_ch1_cnt/_lck          free-running counts from photon_counter
//   c_cnt_clr               drives the counter's reset
//   c_busy                  high while not idle
//   c_bin_valid/ready       result handshake
//   c_bin_cnt/_lck/_idx     window count deltas and window index
//   c_overrun               sticky: a completed window was dropped
module pmt_gate_sequencer #(
  parameter int unsigned COUNTSIZE = 32,
  parameter int unsigned BINSIZE   = 16
) (
  input  logic                 c_clk,
  input  logic                 c_rst,
  input  logic                 c_start,
  input  logic                 c_abort,
  input  logic [COUNTSIZE-1:0] c_gate_period,
  input  logic [BINSIZE-1:0]   c_num_bins,
  input  logic [COUNTSIZE-1:0] c_ch1_cnt,
  input  logic [COUNTSIZE-1:0] c_ch1_cnt_lck,
  output logic                 c_cnt_clr,
  output logic                 c_busy,
  output logic                 c_bin_valid,
  input  logic                 c_bin_ready,
  output logic [COUNTSIZE-1:0] c_bin_cnt,
  output logic [COUNTSIZE-1:0] c_bin_lck,
  output logic [BINSIZE-1:0]   c_bin_idx,
  output logic                 c_overrun
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CLEAR  = 2'd1,
    ST_SETTLE = 2'd2,
    ST_RUN    = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic [COUNTSIZE-1:0] period_q, period_d;
  logic [BINSIZE-1:0]   num_bins_q, num_bins_d;
  logic [COUNTSIZE-1:0] timer_q, timer_d;
  logic [BINSIZE-1:0]   bin_ctr_q, bin_ctr_d;
  logic [COUNTSIZE-1:0] base_cnt_q, base_cnt_d;
  logic [COUNTSIZE-1:0] base_lck_q, base_lck_d;
  logic                 valid_q, valid_d;
  logic [COUNTSIZE-1:0] bin_cnt_q, bin_cnt_d;
  logic [COUNTSIZE-1:0] bin_lck_q, bin_lck_d;
  logic [BINSIZE-1:0]   bin_idx_q, bin_idx_d;
  logic                 overrun_q, overrun_d;
  logic                 cnt_clr_q, cnt_clr_d;
  logic                 busy_q, busy_d;

  logic                 start_ok;
  logic                 win_done;
  logic                 last_bin;
  logic                 load;
  logic [BINSIZE-1:0]   bin_ctr_inc;

  assign start_ok    = c_start && (c_gate_period != '0);
  assign win_done    = (state_q == ST_RUN) && (timer_q == period_q);
  assign bin_ctr_inc = bin_ctr_q + BINSIZE'(1);
  assign last_bin    = (num_bins_q != '0) && (bin_ctr_inc == num_bins_q);
  // Result register takes a new window only if empty or drained this cycle.
  assign load        = win_done && (!valid_q || c_bin_ready);

  // State register
  always_ff @(posedge c_clk or posedge c_rst) begin
    if (c_rst) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic; abort wins over everything except emitting a finished window
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (start_ok) state_d = ST_CLEAR;
      ST_CLEAR:  state_d = c_abort ? ST_IDLE : ST_SETTLE;
      ST_SETTLE: state_d = c_abort ? ST_IDLE : ST_RUN;
      ST_RUN:    if (c_abort || (win_done && last_bin)) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Output and datapath next values
  always_comb begin
    period_d   = period_q;
    num_bins_d = num_bins_q;
    timer_d    = timer_q;
    bin_ctr_d  = bin_ctr_q;
    base_cnt_d = base_cnt_q;
    base_lck_d = base_lck_q;
    valid_d    = valid_q;
    bin_cnt_d  = bin_cnt_q;
    bin_lck_d  = bin_lck_q;
    bin_idx_d  = bin_idx_q;
    overrun_d  = overrun_q;
    cnt_clr_d  = (state_d == ST_CLEAR);
    busy_d     = (state_d != ST_IDLE);

    case (state_q)
      ST_IDLE: begin
        if (start_ok) begin
          period_d   = c_gate_period;
          num_bins_d = c_num_bins;
          overrun_d  = 1'b0;
          bin_ctr_d  = '0;
        end
      end
      ST_CLEAR: begin
        base_cnt_d = '0;
        base_lck_d = '0;
      end
      ST_SETTLE: timer_d = COUNTSIZE'(1);
      ST_RUN: begin
        timer_d = timer_q + COUNTSIZE'(1);
        if (win_done) begin
          // Base always moves so windows stay contiguous even when a result is dropped.
          timer_d    = COUNTSIZE'(1);
          base_cnt_d = c_ch1_cnt;
          base_lck_d = c_ch1_cnt_lck;
          bin_ctr_d  = bin_ctr_inc;
          if (load) begin
            bin_cnt_d = c_ch1_cnt - base_cnt_q;
            bin_lck_d = c_ch1_cnt_lck - base_lck_q;
            bin_idx_d = bin_ctr_q;
          end else begin
            overrun_d = 1'b1;
          end
        end
      end
      default: ;
    endcase

    if (valid_q && c_bin_ready) valid_d = 1'b0;
    if (load)                   valid_d = 1'b1;
  end

  // Datapath and output registers
  always_ff @(posedge c_clk or posedge c_rst) begin
    if (c_rst) begin
      period_q   <= '0;
      num_bins_q <= '0;
      timer_q    <= '0;
      bin_ctr_q  <= '0;
      base_cnt_q <= '0;
      base_lck_q <= '0;
      valid_q    <= 1'b0;
      bin_cnt_q  <= '0;
      bin_lck_q  <= '0;
      bin_idx_q  <= '0;
      overrun_q  <= 1'b0;
      cnt_clr_q  <= 1'b1;
      busy_q     <= 1'b0;
    end else begin
      period_q   <= period_d;
      num_bins_q <= num_bins_d;
      timer_q    <= timer_d;
      bin_ctr_q  <= bin_ctr_d;
      base_cnt_q <= base_cnt_d;
      base_lck_q <= base_lck_d;
      valid_q    <= valid_d;
      bin_cnt_q  <= bin_cnt_d;
      bin_lck_q  <= bin_lck_d;
      bin_idx_q  <= bin_idx_d;
      overrun_q  <= overrun_d;
      cnt_clr_q  <= cnt_clr_d;
      busy_q     <= busy_d;
    end
  end

  assign c_cnt_clr   = cnt_clr_q;
  assign c_busy      = busy_q;
  assign c_bin_valid = valid_q;
  assign c_bin_cnt   = bin_cnt_q;
  assign c_bin_lck   = bin_lck_q;
  assign c_bin_idx   = bin_idx_q;
  assign c_overrun   = overrun_q;

endmodule

// File: tb/tb_pmt_gate_sequencer.sv
// Testbench for pmt_gate_sequencer: directed vectors, queue-based scoreboard.
module tb_pmt_gate_sequencer;

  logic        c_clk = 1'b0;
  logic        c_rst;
  logic        c_start, c_abort;
  logic [31:0] c_gate_period;
  logic [15:0] c_num_bins;
  logic [31:0] c_ch1_cnt, c_ch1_cnt_lck;
  logic        c_cnt_clr, c_busy, c_bin_valid, c_bin_ready, c_overrun;
  logic [31:0] c_bin_cnt, c_bin_lck;
  logic [15:0] c_bin_idx;

  always #5 c_clk = ~c_clk;

  pmt_gate_sequencer #(.COUNTSIZE(32), .BINSIZE(16)) dut (
    .c_clk(c_clk), .c_rst(c_rst), .c_start(c_start), .c_abort(c_abort),
    .c_gate_period(c_gate_period), .c_num_bins(c_num_bins),
    .c_ch1_cnt(c_ch1_cnt), .c_ch1_cnt_lck(c_ch1_cnt_lck),
    .c_cnt_clr(c_cnt_clr), .c_busy(c_busy), .c_bin_valid(c_bin_valid),
    .c_bin_ready(c_bin_ready), .c_bin_cnt(c_bin_cnt), .c_bin_lck(c_bin_lck),
    .c_bin_idx(c_bin_idx), .c_overrun(c_overrun)
  );

  // Photon counter stand-in: cleared by c_cnt_clr, counts edges per inc_mode.
  logic [31:0] m_cnt = '0, m_lck = '0;
  logic        alt_q = 1'b0;
  int unsigned ph_q = 0;
  logic [1:0]  inc_mode = 2'd0;   // 0 none, 1 every clk, 2 every other clk
  logic        updown = 1'b0;     // lock-in counts down during second half of 10-cycle phase
  logic        force_en = 1'b0;
  logic [31:0] f_cnt = '0, f_lck = '0;
  logic        pulse;

  assign pulse         = (inc_mode == 2'd1) || ((inc_mode == 2'd2) && alt_q);
  assign c_ch1_cnt     = force_en ? f_cnt : m_cnt;
  assign c_ch1_cnt_lck = force_en ? f_lck : m_lck;

  always @(posedge c_clk) begin
    alt_q <= ~alt_q;
    ph_q  <= (ph_q == 9) ? 0 : ph_q + 1;
  end

  always @(posedge c_clk or posedge c_cnt_clr) begin
    if (c_cnt_clr) begin
      m_cnt <= '0;
      m_lck <= '0;
    end else if (pulse) begin
      m_cnt <= m_cnt + 32'd1;
      m_lck <= (updown && ph_q >= 5) ? m_lck - 32'd1 : m_lck + 32'd1;
    end
  end

  typedef struct packed {
    logic [31:0] cnt;
    logic [31:0] lck;
    logic [15:0] idx;
  } res_t;

  res_t exp_q[$];
  res_t e_r, g_r;
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic push(input logic [31:0] cnt, input logic [31:0] lck, input logic [15:0] idx);
    res_t r;
    r.cnt = cnt; r.lck = lck; r.idx = idx;
    exp_q.push_back(r);
  endtask

  // Monitor: compare every accepted result against the scoreboard head
  always @(negedge c_clk) begin
    if (!c_rst && c_bin_valid && c_bin_ready) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        $display("FAIL unexpected_result: got idx %0d cnt 0x%0h, expected no result",
                 c_bin_idx, c_bin_cnt);
      end else begin
        e_r = exp_q.pop_front();
        g_r = {c_bin_cnt, c_bin_lck, c_bin_idx};
        if (g_r === e_r) n_pass++;
        else $display("FAIL result: got cnt 0x%0h lck 0x%0h idx %0d expected cnt 0x%0h lck 0x%0h idx %0d",
                      g_r.cnt, g_r.lck, g_r.idx, e_r.cnt, e_r.lck, e_r.idx);
      end
    end
  end

  task automatic tick();
    @(posedge c_clk);
    #1;
  endtask

  task automatic start(input logic [31:0] per, input logic [15:0] nb);
    c_gate_period = per;
    c_num_bins    = nb;
    c_start       = 1'b1;
    tick();
    c_start       = 1'b0;
  endtask

  task automatic wait_valid(input string name, input int maxc);
    logic seen = 1'b0;
    for (int i = 0; i < maxc && !seen; i++) begin
      tick();
      seen = c_bin_valid;
    end
    check(name, 32'(seen), 32'd1);
  endtask

  task automatic wait_drain(input string name, input int maxc);
    logic done = 1'b0;
    for (int i = 0; i < maxc && !done; i++) begin
      tick();
      done = (exp_q.size() == 0);
    end
    check(name, 32'(done), 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    c_rst = 1'b1; c_start = 1'b0; c_abort = 1'b0;
    c_gate_period = '0; c_num_bins = '0; c_bin_ready = 1'b1;
    repeat (3) @(posedge c_clk);
    #1;
    check("rst_cnt_clr", 32'(c_cnt_clr), 32'd1);
    check("rst_busy",    32'(c_busy),    32'd0);
    check("rst_valid",   32'(c_bin_valid), 32'd0);
    check("rst_overrun", 32'(c_overrun), 32'd0);
    check("rst_bin_cnt", c_bin_cnt, 32'd0);
    check("rst_bin_idx", 32'(c_bin_idx), 32'd0);
    c_rst = 1'b0;
    tick();
    check("idle_cnt_clr", 32'(c_cnt_clr), 32'd0);

    // Start with period 0 is ignored
    start(32'd0, 16'd3);
    check("p0_busy", 32'(c_busy), 32'd0);
    tick();
    check("p0_cnt_clr", 32'(c_cnt_clr), 32'd0);

    // Basic: period 10, 3 bins, edge every other clock
    inc_mode = 2'd2; updown = 1'b0;
    for (int i = 0; i < 3; i++) push(32'd5, 32'd5, 16'(i));
    start(32'd10, 16'd3);
    check("t1_busy", 32'(c_busy), 32'd1);
    check("t1_clr_on", 32'(c_cnt_clr), 32'd1);
    tick();
    check("t1_clr_off", 32'(c_cnt_clr), 32'd0);
    c_gate_period = 32'd3; c_start = 1'b1;   // start while busy: ignored
    tick();
    c_start = 1'b0;
    wait_drain("t1_drain", 100);
    check("t1_busy_end", 32'(c_busy), 32'd0);

    // Lock-in up/down cancels over a 20-cycle window
    inc_mode = 2'd1; updown = 1'b1;
    for (int i = 0; i < 3; i++) push(32'd20, 32'd0, 16'(i));
    start(32'd20, 16'd3);
    wait_drain("t2_drain", 200);
    check("t2_busy_end", 32'(c_busy), 32'd0);

    // Overrun: consumer stalls across windows 1 and 2
    updown = 1'b0; c_bin_ready = 1'b0;
    push(32'd8, 32'd8, 16'd0);
    push(32'd8, 32'd8, 16'd3);
    push(32'd8, 32'd8, 16'd4);
    start(32'd8, 16'd5);
    wait_valid("t3_valid", 50);
    repeat (19) tick();
    check("t3_overrun", 32'(c_overrun), 32'd1);
    c_bin_ready = 1'b1;
    wait_drain("t3_drain", 100);
    check("t3_overrun_sticky", 32'(c_overrun), 32'd1);
    check("t3_busy_end", 32'(c_busy), 32'd0);

    // Wrap-safe deltas with forced counter values
    force_en = 1'b1; f_cnt = 32'hFFFF_FFFE; f_lck = 32'd2;
    push(32'hFFFF_FFFE, 32'd2, 16'd0);
    push(32'd5, 32'hFFFF_FFFB, 16'd1);
    start(32'd4, 16'd2);
    check("t4_overrun_clr", 32'(c_overrun), 32'd0);
    wait_valid("t4_valid", 20);
    f_cnt = 32'd3; f_lck = 32'hFFFF_FFFD;
    wait_drain("t4_drain", 50);
    force_en = 1'b0;

    // Continuous mode aborted at RUN cycle 57 of a 20-cycle period
    inc_mode = 2'd1;
    push(32'd20, 32'd20, 16'd0);
    push(32'd20, 32'd20, 16'd1);
    start(32'd20, 16'd0);
    repeat (58) tick();
    check("t5_busy_pre", 32'(c_busy), 32'd1);
    c_abort = 1'b1;
    tick();
    c_abort = 1'b0;
    check("t5_busy_post", 32'(c_busy), 32'd0);
    repeat (30) tick();
    check("t5_drained", 32'(exp_q.size()), 32'd0);

    // Async reset mid-run with a pending result
    c_bin_ready = 1'b0;
    start(32'd8, 16'd0);
    wait_valid("t6_valid", 30);
    repeat (10) tick();
    check("t6_overrun_pre", 32'(c_overrun), 32'd1);
    c_rst = 1'b1;
    #1;
    check("t6_cnt_clr", 32'(c_cnt_clr), 32'd1);
    check("t6_busy",    32'(c_busy), 32'd0);
    check("t6_valid",   32'(c_bin_valid), 32'd0);
    check("t6_overrun", 32'(c_overrun), 32'd0);
    check("t6_bin_cnt", c_bin_cnt, 32'd0);
    check("t6_bin_lck", c_bin_lck, 32'd0);
    exp_q.delete();
    tick();
    c_rst = 1'b0; c_bin_ready = 1'b1;
    tick();
    push(32'd6, 32'd6, 16'd0);
    push(32'd6, 32'd6, 16'd1);
    start(32'd6, 16'd2);
    wait_drain("t6_restart", 60);
    check("t6_busy_end", 32'(c_busy), 32'd0);

    repeat (5) tick();
    check("final_empty", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
